// File: rtl/sweep_sequencer_pkg.sv
// Shared types and default sizing for the read-address sweep sequencer.
// Optional feature macro SWEEP_REVERSE_EN is handled in the interface and top.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SWEEP  = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int SWEEP_DEPTH  = 32;
   localparam int SWEEP_SETTLE = 127;

endpackage

// File: rtl/sweep_sequencer_if.sv
// Handshake/control bundle between writer, sweep sequencer and read consumer.
// Defining SWEEP_REVERSE_EN adds the dir input (descending sweep select).
interface sweep_sequencer_if #(
   parameter int ADDR_W = 5
);
   logic              write_done;
   logic              cleared;
   logic              loop_mode;
   logic              rd_ready;
`ifdef SWEEP_REVERSE_EN
   logic              dir;
`endif
   logic              start;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_addr;
   logic              sweep_done;
   logic              busy;

`ifdef SWEEP_REVERSE_EN
   modport master (
      input  write_done, cleared, loop_mode, rd_ready, dir,
      output start, rd_valid, rd_addr, sweep_done, busy
   );
   modport slave (
      output write_done, cleared, loop_mode, rd_ready, dir,
      input  start, rd_valid, rd_addr, sweep_done, busy
   );
`else
   modport master (
      input  write_done, cleared, loop_mode, rd_ready,
      output start, rd_valid, rd_addr, sweep_done, busy
   );
   modport slave (
      output write_done, cleared, loop_mode, rd_ready,
      input  start, rd_valid, rd_addr, sweep_done, busy
   );
`endif
endinterface

// File: rtl/sweep_sequencer_settle_timer.sv
// Settle interval counter: counts while enabled, expire marks the final settle edge.
module settle_timer #(
   parameter int SETTLE_W   = 11,
   parameter int SETTLE_CYC = 127
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expire
);
   logic [SETTLE_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (enable)
         count_d = count_q + SETTLE_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign expire = enable && (count_q == SETTLE_W'(SETTLE_CYC - 1));
endmodule

// File: rtl/sweep_sequencer.sv
// Settle-then-sweep read address sequencer with one-shot/loop modes.
// Optional: SWEEP_REVERSE_EN adds a dir input selecting a descending sweep.
module sweep_sequencer
   import sweep_pkg::*;
#(
   parameter int DEPTH      = SWEEP_DEPTH,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int SETTLE_CYC = SWEEP_SETTLE,
   parameter int SETTLE_W   = 11
) (
   input  logic              clk,
   input  logic              reset,
   sweep_sequencer_if.master bus
);
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic              start_q, start_d;
   logic              rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              sweep_done_q, sweep_done_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] first_addr, last_addr, step_addr;
   logic              abort, beat, last_beat, settle_expire;
`ifdef SWEEP_REVERSE_EN
   logic              dir_q, dir_d;
`endif

   settle_timer #(
      .SETTLE_W   (SETTLE_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_settle (
      .clk    (clk),
      .reset  (reset),
      .enable (state_q == SETTLE),
      .clear  (state_q != SETTLE || abort),
      .expire (settle_expire)
   );

   // Direction applies to the running sweep; the live dir only picks the next start point.
`ifdef SWEEP_REVERSE_EN
   assign first_addr = bus.dir ? '0 - '0 + ADDR_MAX : '0;
   assign last_addr  = dir_q ? '0 : ADDR_MAX;
   assign step_addr  = dir_q ? rd_addr_q - ADDR_W'(1) : rd_addr_q + ADDR_W'(1);
`else
   assign first_addr = '0;
   assign last_addr  = ADDR_MAX;
   assign step_addr  = rd_addr_q + ADDR_W'(1);
`endif

   assign abort     = bus.cleared || !bus.write_done;
   assign beat      = rd_valid_q && bus.rd_ready;
   assign last_beat = beat && (rd_addr_q == last_addr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         start_q      <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_addr_q    <= '0;
         sweep_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         rd_valid_q   <= rd_valid_d;
         rd_addr_q    <= rd_addr_d;
         sweep_done_q <= sweep_done_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.write_done && !bus.cleared) state_d = SETTLE;
         SETTLE:  if (abort) state_d = IDLE; else if (settle_expire) state_d = SWEEP;
         SWEEP:   if (abort) state_d = IDLE; else if (last_beat && !bus.loop_mode) state_d = DONE;
         DONE:    if (abort) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are derived from the next state so every output is a flop.
   always_comb begin
      start_d      = 1'b0;
      rd_valid_d   = 1'b0;
      rd_addr_d    = '0;
      sweep_done_d = 1'b0;
      busy_d       = (state_d != IDLE);
      unique case (state_d)
         SWEEP: begin
            start_d    = 1'b1;
            rd_valid_d = 1'b1;
            rd_addr_d  = rd_addr_q;
            if (state_q == SETTLE) begin
               rd_addr_d = first_addr;
            end else if (last_beat) begin
               rd_addr_d    = first_addr;
               sweep_done_d = 1'b1;
            end else if (beat) begin
               rd_addr_d = step_addr;
            end
         end
         DONE: begin
            start_d      = 1'b1;
            rd_addr_d    = rd_addr_q;
            sweep_done_d = (state_q == SWEEP);
         end
         default: ;
      endcase
   end

`ifdef SWEEP_REVERSE_EN
   always_comb begin
      dir_d = dir_q;
      if (state_d == SWEEP && (state_q == SETTLE || last_beat))
         dir_d = bus.dir;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         dir_q <= 1'b0;
      else
         dir_q <= dir_d;
   end
`endif

   assign bus.start      = start_q;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.sweep_done = sweep_done_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer (DEPTH=32, SETTLE_CYC=127).
// Reverse-sweep checks run only when SWEEP_REVERSE_EN is defined.
module tb_sweep_sequencer;
   import sweep_pkg::*;

   localparam int DEPTH  = 32;
   localparam int SETTLE = 127;
   localparam int AW     = 5;

   logic clk;
   logic reset;
   logic tb_dir;

   sweep_sequencer_if #(.ADDR_W(AW)) bus ();

`ifdef SWEEP_REVERSE_EN
   assign bus.dir = tb_dir;
`endif

   sweep_sequencer #(
      .DEPTH      (DEPTH),
      .ADDR_W     (AW),
      .SETTLE_CYC (SETTLE),
      .SETTLE_W   (11)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
   endtask

   // Behavioural model: qualifying-edge count and accepted-beat count define every output.
   int m_qual, m_beats;
   bit m_fin, m_pulse, m_rev;
   bit exp_busy, exp_start, exp_valid;
   int exp_addr, pos;

   always_comb begin
      exp_busy  = (m_qual > 0);
      exp_start = (m_qual > SETTLE);
      exp_valid = exp_start && !m_fin;
      pos       = m_beats % DEPTH;
      if (!exp_start)  exp_addr = 0;
      else if (m_fin)  exp_addr = m_rev ? 0 : DEPTH - 1;
      else             exp_addr = m_rev ? DEPTH - 1 - pos : pos;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_qual <= 0; m_beats <= 0; m_fin <= 0; m_pulse <= 0; m_rev <= 0;
      end else if (!bus.write_done || bus.cleared) begin
         m_qual <= 0; m_beats <= 0; m_fin <= 0; m_pulse <= 0;
      end else begin
         m_qual  <= (m_qual < 100000) ? m_qual + 1 : m_qual;
         m_pulse <= 0;
         if (m_qual == SETTLE) m_rev <= tb_dir;
         if (exp_valid && bus.rd_ready) begin
            m_beats <= m_beats + 1;
            if ((m_beats + 1) % DEPTH == 0) begin
               m_pulse <= 1;
               if (bus.loop_mode) m_rev <= tb_dir;
               else m_fin <= 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("busy",       int'(bus.busy),       int'(exp_busy));
      chk("start",      int'(bus.start),      int'(exp_start));
      chk("rd_valid",   int'(bus.rd_valid),   int'(exp_valid));
      chk("rd_addr",    int'(bus.rd_addr),    exp_addr);
      chk("sweep_done", int'(bus.sweep_done), int'(m_pulse));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Edges until start is seen, bounded; -1 on timeout.
   task automatic wait_start(output int n);
      n = 0;
      while (!bus.start && n < 400) begin
         tick();
         n++;
      end
      if (!bus.start) n = -1;
   endtask

   task automatic abort_idle();
      bus.write_done = 1'b0;
      tick();
      bus.write_done = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   int n, acc, pulses, cyc;

   initial begin
      reset = 1'b0;
      tb_dir = 1'b0;
      bus.write_done = 1'b0;
      bus.cleared    = 1'b0;
      bus.loop_mode  = 1'b0;
      bus.rd_ready   = 1'b0;
      repeat (3) tick();
      chk("rst_busy",  int'(bus.busy),     0);
      chk("rst_start", int'(bus.start),    0);
      chk("rst_valid", int'(bus.rd_valid), 0);
      chk("rst_addr",  int'(bus.rd_addr),  0);
      reset = 1'b1;

      // One-shot ascending sweep
      bus.write_done = 1'b1;
      bus.rd_ready   = 1'b1;
      wait_start(n);
      chk("t1_latency", n, 128);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t1_addr", int'(bus.rd_addr), i);
         tick();
      end
      chk("t1_done_pulse", int'(bus.sweep_done), 1);
      chk("t1_valid_off",  int'(bus.rd_valid),   0);
      chk("t1_addr_hold",  int'(bus.rd_addr),    31);
      tick();
      chk("t1_done_once",  int'(bus.sweep_done), 0);
      chk("t1_start_held", int'(bus.start),      1);

      // Drop write_done partway through settle
      bus.write_done = 1'b0;
      tick();
      chk("t2_idle", int'(bus.busy), 0);
      bus.write_done = 1'b1;
      repeat (61) tick();
      chk("t2_settling", int'(bus.busy), 1);
      bus.write_done = 1'b0;
      tick();
      chk("t2_abort_start", int'(bus.start), 0);
      chk("t2_abort_busy",  int'(bus.busy),  0);
      bus.write_done = 1'b1;
      wait_start(n);
      chk("t2_latency", n, 128);

      // Alternating ready
      abort_idle();
      wait_start(n);
      acc = 0;
      cyc = 0;
      while (cyc < 200) begin
         bus.rd_ready = cyc[0];
         if (bus.rd_valid && bus.rd_ready) acc++;
         tick();
         cyc++;
         if (bus.sweep_done) break;
      end
      chk("t3_beats", acc, 32);
      chk("t3_done",  int'(bus.sweep_done), 1);

      // Loop mode, then clear mid-lap
      bus.rd_ready  = 1'b1;
      bus.loop_mode = 1'b1;
      abort_idle();
      wait_start(n);
      pulses = 0;
      repeat (42) begin
         tick();
         if (bus.sweep_done) pulses++;
      end
      chk("t4_pulses", pulses, 1);
      chk("t4_addr",   int'(bus.rd_addr), 10);
      bus.cleared = 1'b1;
      tick();
      chk("t4_clr_valid", int'(bus.rd_valid), 0);
      chk("t4_clr_start", int'(bus.start),    0);
      chk("t4_clr_addr",  int'(bus.rd_addr),  0);
      chk("t4_clr_busy",  int'(bus.busy),     0);
      bus.cleared = 1'b0;

      // Asynchronous reset mid-sweep
      wait_start(n);
      repeat (17) tick();
      chk("t5_addr", int'(bus.rd_addr), 17);
      #2 reset = 1'b0;
      #1;
      chk("t5_async_start", int'(bus.start),    0);
      chk("t5_async_valid", int'(bus.rd_valid), 0);
      chk("t5_async_addr",  int'(bus.rd_addr),  0);
      chk("t5_async_busy",  int'(bus.busy),     0);
      tick();
      reset = 1'b1;
      wait_start(n);
      chk("t5_latency", n, 128);

`ifdef SWEEP_REVERSE_EN
      // Descending sweep with loop reload
      tb_dir = 1'b1;
      abort_idle();
      wait_start(n);
      chk("t6_first", int'(bus.rd_addr), 31);
      repeat (31) tick();
      chk("t6_last", int'(bus.rd_addr), 0);
      tick();
      chk("t6_done",   int'(bus.sweep_done), 1);
      chk("t6_reload", int'(bus.rd_addr),    31);
`endif

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
